// File: rtl/psg_dram_bridge_if.sv
// AXI4-Lite style DRAM channel between the PSG bridge (master) and the DRAM model (slave).
// Handshake rule on every channel: a transfer happens on the rising clk edge where
// VALID and READY are both 1. The source holds VALID and its payload steady until
// that edge. READY may already be high in the cycle VALID rises.
interface psg_dram_bridge_if #(
  parameter int DATA_W = 64
) ();
  logic              AR_VALID;
  logic [16:0]       AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [16:0]       AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;

  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
endinterface

// File: rtl/psg_dram_bridge.sv
// Bridge from the PSG controller's one-shot DRAM request channel to an AXI4-Lite
// DRAM slave. One Player_Info record per request, one request in flight; the
// completion is a single-cycle C_out_valid pulse. All bus outputs are decoded
// from the registered state so that reset clears them immediately.
module psg_dram_bridge #(
  parameter logic [16:0] BASE_ADDR = 17'h10000,
  parameter int          ID_W      = 8,
  parameter int          DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   C_addr,
  input  logic [DATA_W-1:0] C_data_w,
  input  logic              C_in_valid,
  input  logic              C_r_wb,
  output logic              C_out_valid,
  output logic [DATA_W-1:0] C_data_r,
  psg_dram_bridge_if.master dram,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   id_q;
  logic              rd_q;
  // Holds the write record during a write and the captured read record on a read.
  logic [DATA_W-1:0] data_q;
  logic [16:0]       addr;
  logic              unused_resp;

  // Responses are not acted on; every transaction completes normally.
  assign unused_resp = ^{dram.R_RESP, dram.B_RESP};

  assign addr      = BASE_ADDR + 17'({id_q, 3'b000});
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Request latch in IDLE and read-data capture in R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      rd_q   <= 1'b0;
      data_q <= '0;
    end else if (state == S_IDLE && C_in_valid) begin
      id_q   <= C_addr;
      rd_q   <= C_r_wb;
      data_q <= C_data_w;
    end else if (state == S_R && dram.R_VALID) begin
      data_q <= dram.R_DATA;
    end
  end

  // Next-state and output decode; payloads read 0 outside their VALID window.
  always_comb begin
    state_nxt     = state;
    C_out_valid   = 1'b0;
    C_data_r      = '0;
    dram.AR_VALID = 1'b0;
    dram.AR_ADDR  = '0;
    dram.R_READY  = 1'b0;
    dram.AW_VALID = 1'b0;
    dram.AW_ADDR  = '0;
    dram.W_VALID  = 1'b0;
    dram.W_DATA   = '0;
    dram.B_READY  = 1'b0;
    case (state)
      S_IDLE: begin
        if (C_in_valid) state_nxt = C_r_wb ? S_AR : S_AW;
      end
      S_AR: begin
        dram.AR_VALID = 1'b1;
        dram.AR_ADDR  = addr;
        if (dram.AR_READY) state_nxt = S_R;
      end
      S_R: begin
        dram.R_READY = 1'b1;
        if (dram.R_VALID) state_nxt = S_OUT;
      end
      S_AW: begin
        dram.AW_VALID = 1'b1;
        dram.AW_ADDR  = addr;
        if (dram.AW_READY) state_nxt = S_W;
      end
      S_W: begin
        dram.W_VALID = 1'b1;
        dram.W_DATA  = data_q;
        if (dram.W_READY) state_nxt = S_B;
      end
      S_B: begin
        dram.B_READY = 1'b1;
        if (dram.B_VALID) state_nxt = S_OUT;
      end
      S_OUT: begin
        C_out_valid = 1'b1;
        C_data_r    = rd_q ? data_q : '0;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_psg_dram_bridge.sv
// Bench for psg_dram_bridge: a per-cycle expected timeline is built from the
// request/stall rules, a DRAM memory model supplies read data, and one compare
// process checks every output on the falling edge.
module tb_psg_dram_bridge;
  localparam logic [16:0] BASE = 17'h10000;

  logic        clk;
  logic        rst_n;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_in_valid;
  logic        C_r_wb;
  logic        C_out_valid;
  logic [63:0] C_data_r;
  logic [2:0]  dbg_state;

  psg_dram_bridge_if #(.DATA_W(64)) bus ();

  psg_dram_bridge #(.BASE_ADDR(BASE), .ID_W(8), .DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .C_addr     (C_addr),
    .C_data_w   (C_data_w),
    .C_in_valid (C_in_valid),
    .C_r_wb     (C_r_wb),
    .C_out_valid(C_out_valid),
    .C_data_r   (C_data_r),
    .dram       (bus.master),
    .dbg_state  (dbg_state)
  );

  typedef struct packed {
    logic        in_reset;
    logic        ar_valid;
    logic [16:0] ar_addr;
    logic        r_ready;
    logic        aw_valid;
    logic [16:0] aw_addr;
    logic        w_valid;
    logic [63:0] w_data;
    logic        b_ready;
    logic        out_valid;
    logic [63:0] data_r;
  } exp_t;

  exp_t exp_cur;
  bit   exp_en;
  int   n_checks;
  int   n_errors;
  logic [63:0] mem [logic [16:0]];
  logic [63:0] exp_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (exp_en) begin
      check("ar_valid",  64'(bus.AR_VALID), 64'(exp_cur.ar_valid));
      check("ar_addr",   64'(bus.AR_ADDR),  64'(exp_cur.ar_addr));
      check("r_ready",   64'(bus.R_READY),  64'(exp_cur.r_ready));
      check("aw_valid",  64'(bus.AW_VALID), 64'(exp_cur.aw_valid));
      check("w_valid",   64'(bus.W_VALID),  64'(exp_cur.w_valid));
      check("b_ready",   64'(bus.B_READY),  64'(exp_cur.b_ready));
      check("out_valid", 64'(C_out_valid),  64'(exp_cur.out_valid));
      check("data_r",    C_data_r,          exp_cur.data_r);
      if (exp_cur.aw_valid || exp_cur.in_reset) check("aw_addr", 64'(bus.AW_ADDR), 64'(exp_cur.aw_addr));
      if (exp_cur.w_valid || exp_cur.in_reset)  check("w_data",  bus.W_DATA, exp_cur.w_data);
      if (exp_cur.in_reset) check("dbg_state_rst", 64'(dbg_state), 64'd0);
      if (C_out_valid) begin
        if (exp_q.size() == 0) check("unexpected_completion", 64'd1, 64'd0);
        else check("scoreboard_data", C_data_r, exp_q.pop_front());
      end
    end
  end

  task automatic drive_quiet();
    C_in_valid   = 1'b0;
    C_r_wb       = 1'($urandom);
    C_addr       = 8'($urandom);
    C_data_w     = {$urandom, $urandom};
    bus.AR_READY = 1'b0;
    bus.R_VALID  = 1'b0;
    bus.R_DATA   = {$urandom, $urandom};
    bus.R_RESP   = 2'($urandom_range(0, 3));
    bus.AW_READY = 1'b0;
    bus.W_READY  = 1'b0;
    bus.B_VALID  = 1'b0;
    bus.B_RESP   = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_quiet();
      exp_cur = '0;
    end
  endtask

  // One request; d1/d2/d3 are slave stall cycles on the address, data and response phases.
  task automatic run_txn(input bit rd, input logic [7:0] id, input logic [63:0] wd,
                         input int d1, input int d2, input int d3, input bit dup,
                         input int rst_k, input bit lit_en, input logic [16:0] lit_addr,
                         input logic [63:0] lit_data);
    logic [16:0] a;
    logic [63:0] rv;
    exp_t        e;
    int          last;
    bit          aborted;
    a  = BASE + 17'(id) * 17'd8;
    rv = '0;
    if (rd) begin
      if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
      rv = mem[a];
    end
    last    = rd ? 3 + d1 + d2 : 4 + d1 + d2 + d3;
    aborted = 1'b0;
    if (rst_k < 0) exp_q.push_back(rd ? rv : 64'd0);
    for (int k = 0; k <= last && !aborted; k++) begin
      @(posedge clk); #1;
      drive_quiet();
      e = '0;
      if (k == 0) begin
        C_in_valid = 1'b1;
        C_r_wb     = rd;
        C_addr     = id;
        C_data_w   = wd;
      end else if (dup && k == 2 + d1) begin
        C_in_valid = 1'b1;
      end
      if (rd) begin
        bus.AR_READY = (k == 1 + d1);
        bus.R_VALID  = (k == 2 + d1 + d2);
        if (k == 2 + d1 + d2) bus.R_DATA = rv;
        e.ar_valid = (k >= 1 && k <= 1 + d1);
        e.ar_addr  = e.ar_valid ? a : 17'd0;
        e.r_ready  = (k >= 2 + d1 && k <= 2 + d1 + d2);
      end else begin
        bus.AW_READY = (k == 1 + d1);
        bus.W_READY  = (k == 2 + d1 + d2);
        bus.B_VALID  = (k == 3 + d1 + d2 + d3);
        e.aw_valid = (k >= 1 && k <= 1 + d1);
        e.aw_addr  = a;
        e.w_valid  = (k >= 2 + d1 && k <= 2 + d1 + d2);
        e.w_data   = wd;
        e.b_ready  = (k >= 3 + d1 + d2 && k <= 3 + d1 + d2 + d3);
      end
      e.out_valid = (k == last);
      e.data_r    = (k == last && rd) ? rv : 64'd0;
      if (k == rst_k) begin
        rst_n      = 1'b0;
        e          = '0;
        e.in_reset = 1'b1;
        aborted    = 1'b1;
      end
      exp_cur = e;
      if (lit_en && k == 1) check("lit_addr", 64'(rd ? bus.AR_ADDR : bus.AW_ADDR), 64'(lit_addr));
      if (lit_en && k == last) begin
        check("lit_out_valid", 64'(C_out_valid), 64'd1);
        check("lit_data_r", C_data_r, lit_data);
      end
    end
    if (aborted) begin
      @(posedge clk); #1;
      drive_quiet();
      rst_n   = 1'b1;
      exp_cur = '0;
    end else if (!rd) begin
      mem[a] = wd;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_en   = 1'b0;
    exp_cur  = '0;
    rst_n    = 1'b0;
    drive_quiet();
    // Reset state is observed while rst_n is still low.
    @(posedge clk); #1;
    exp_cur          = '0;
    exp_cur.in_reset = 1'b1;
    exp_en           = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    exp_cur = '0;
    idle(2);

    // read id 0, no stalls
    mem[17'h10000] = 64'h0A0B0C0D_12345678;
    run_txn(1'b1, 8'h00, 64'd0, 0, 0, 0, 1'b0, -1, 1'b1, 17'h10000, 64'h0A0B0C0D_12345678);
    idle(1);
    // write id FF, AW_READY delayed 5 cycles
    run_txn(1'b0, 8'hFF, 64'h1111_2222_3333_4444, 5, 0, 0, 1'b0, -1, 1'b1, 17'h107F8, 64'd0);
    idle(1);
    // read id 5, R_VALID delayed 10 cycles
    mem[17'h10028] = 64'hCAFEF00D_55AA55AA;
    run_txn(1'b1, 8'h05, 64'd0, 0, 10, 0, 1'b0, -1, 1'b1, 17'h10028, 64'hCAFEF00D_55AA55AA);
    idle(1);
    // a second request strobed while in R is ignored
    run_txn(1'b1, 8'h07, 64'd0, 1, 3, 0, 1'b1, -1, 1'b0, 17'd0, 64'd0);
    idle(1);
    // reset in the W phase abandons the write
    run_txn(1'b0, 8'h09, 64'h9999_8888_7777_6666, 1, 4, 0, 1'b0, 4, 1'b0, 17'd0, 64'd0);
    idle(2);
    run_txn(1'b1, 8'h02, 64'd0, 0, 0, 0, 1'b0, -1, 1'b0, 17'd0, 64'd0);
    // back-to-back write id 3 then read id 3
    run_txn(1'b0, 8'h03, 64'hDEAD_BEEF_0000_0003, 0, 0, 0, 1'b0, -1, 1'b1, 17'h10018, 64'd0);
    run_txn(1'b1, 8'h03, 64'd0, 0, 0, 0, 1'b0, -1, 1'b1, 17'h10018, 64'hDEAD_BEEF_0000_0003);

    // randomized traffic over a small id set so reads hit earlier writes
    for (int t = 0; t < 60; t++) begin
      logic [7:0] rid;
      rid = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      run_txn(1'($urandom), rid, {$urandom, $urandom},
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              1'($urandom), -1, 1'b0, 17'd0, 64'd0);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
